// File: rtl/pwm_frame_decoder.sv
// Serial thermometer-PWM receiver: aligns to the generator's frame strobe and
// recovers the duty code once per 2**WIDTH-slot frame, flagging bad frames.
module pwm_frame_decoder #(
    parameter int WIDTH = 3,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             serial_in,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] duty_code,
    output logic             duty_valid,
    output logic             idle,
    output logic             frame_err,
    output logic             sync_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [0:0]       ST_UNLOCKED = 1'b0;
    localparam logic [0:0]       ST_LOCKED   = 1'b1;
    localparam logic [WIDTH-1:0] LAST_SLOT   = {WIDTH{1'b1}};

    logic [0:0]       state;
    logic [WIDTH-1:0] slot;
    logic [WIDTH:0]   ones;
    logic             zero_seen;
    logic             shape_bad;

    logic [WIDTH:0]   ones_total;
    logic [WIDTH:0]   ones_m1;
    logic             shape_total;
    logic             bad_sync;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Fold the final sample in combinationally so the frame verdict lands on the last-slot edge.
    always_comb begin
        ones_total  = ones + {{WIDTH{1'b0}}, serial_in};
        ones_m1     = ones_total - {{WIDTH{1'b0}}, 1'b1};
        shape_total = shape_bad | (zero_seen & serial_in);
        bad_sync    = frame_sync && (slot != '0);
    end

    assign locked = (state == ST_LOCKED);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= ST_UNLOCKED;
            slot       <= '0;
            ones       <= '0;
            zero_seen  <= 1'b0;
            shape_bad  <= 1'b0;
            duty_code  <= '0;
            duty_valid <= 1'b0;
            idle       <= 1'b0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            duty_valid <= 1'b0;
            idle       <= 1'b0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;
            if (!enable) begin
                state     <= ST_UNLOCKED;
                slot      <= '0;
                ones      <= '0;
                zero_seen <= 1'b0;
                shape_bad <= 1'b0;
            end else if (state == ST_UNLOCKED || bad_sync) begin
                // Unaligned or slipped: only a frame_sync restarts with this sample as slot 0.
                if (frame_sync) begin
                    state     <= ST_LOCKED;
                    slot      <= {{(WIDTH-1){1'b0}}, 1'b1};
                    ones      <= {{WIDTH{1'b0}}, serial_in};
                    zero_seen <= !serial_in;
                    shape_bad <= 1'b0;
                end
                if (bad_sync) begin
                    sync_err  <= 1'b1;
                    err_count <= sat_inc(err_count);
                end
            end else if (slot == LAST_SLOT) begin
                slot      <= '0;
                ones      <= '0;
                zero_seen <= 1'b0;
                shape_bad <= 1'b0;
                if (ones_total == '0) begin
                    idle <= 1'b1;
                end else if (shape_total) begin
                    frame_err <= 1'b1;
                    err_count <= sat_inc(err_count);
                end else begin
                    duty_code  <= ones_m1[WIDTH-1:0];
                    duty_valid <= 1'b1;
                end
            end else begin
                slot      <= slot + 1'b1;
                ones      <= ones_total;
                zero_seen <= zero_seen | !serial_in;
                shape_bad <= shape_total;
            end
        end
    end

endmodule

// File: tb/tb_pwm_frame_decoder.sv
// Directed bench for pwm_frame_decoder: frames are written slot 0 first (MSB).
module tb_pwm_frame_decoder;

    logic       clock = 1'b0;
    logic       clear_n;
    logic       enable;
    logic       serial_in;
    logic       frame_sync;
    logic [2:0] duty_code;
    logic       duty_valid;
    logic       idle;
    logic       frame_err;
    logic       sync_err;
    logic       locked;
    logic [7:0] err_count;

    int checks   = 0;
    int failures = 0;
    int nv, ni, nfe, nse, valid_idx;

    pwm_frame_decoder #(.WIDTH(3), .ERR_W(8)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .enable     (enable),
        .serial_in  (serial_in),
        .frame_sync (frame_sync),
        .duty_code  (duty_code),
        .duty_valid (duty_valid),
        .idle       (idle),
        .frame_err  (frame_err),
        .sync_err   (sync_err),
        .locked     (locked),
        .err_count  (err_count)
    );

    always #5 clock = ~clock;

    // Drive n slots of pat (slot 0 = bit 7), frame_sync on the first slot if sync set.
    task automatic send_bits(input logic [7:0] pat, input int n, input bit sync);
        nv = 0; ni = 0; nfe = 0; nse = 0; valid_idx = -1;
        for (int i = 0; i < n; i++) begin
            serial_in  = pat[7-i];
            frame_sync = sync && (i == 0);
            @(posedge clock);
            #1;
            if (duty_valid) begin nv++; valid_idx = i; end
            if (idle) ni++;
            if (frame_err) nfe++;
            if (sync_err) nse++;
        end
        frame_sync = 1'b0;
    endtask

    task automatic test_reset;
        clear_n = 1'b0; enable = 1'b0; serial_in = 1'b0; frame_sync = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({duty_code, duty_valid, idle, frame_err, sync_err, locked, err_count} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {duty_code, duty_valid, idle, frame_err, sync_err, locked, err_count});
        end
        clear_n = 1'b1;
        enable  = 1'b1;
        send_bits(8'hF0, 8, 1'b0);
        checks++;
        if (locked !== 1'b0 || nv != 0) begin
            failures++;
            $display("FAIL wait_for_sync locked=%0b valids=%0d exp 0/0", locked, nv);
        end
    endtask

    task automatic test_basic;
        for (int f = 0; f < 3; f++) begin
            send_bits(8'hF0, 8, 1'b1);
            checks++;
            if (nv != 1 || valid_idx != 7 || duty_code !== 3'd3 || locked !== 1'b1 || err_count !== 8'd0) begin
                failures++;
                $display("FAIL basic_code3 frame=%0d valids=%0d idx=%0d code=%0d locked=%0b errs=%0d exp 1/7/3/1/0",
                         f, nv, valid_idx, duty_code, locked, err_count);
            end
        end
    endtask

    task automatic test_sweep;
        logic [7:0] pat;
        for (int c = 0; c < 8; c++) begin
            pat = 8'hFF << (7 - c);
            send_bits(pat, 8, 1'b1);
            checks++;
            if (nv != 1 || duty_code !== 3'(c) || ni != 0) begin
                failures++;
                $display("FAIL sweep code got=%0d valids=%0d exp=%0d valids=1", duty_code, nv, c);
            end
        end
        send_bits(8'h00, 8, 1'b1);
        checks++;
        if (ni != 1 || nv != 0 || duty_code !== 3'd7) begin
            failures++;
            $display("FAIL idle_frame idle=%0d valids=%0d code=%0d exp 1/0/7", ni, nv, duty_code);
        end
    endtask

    task automatic test_frame_err;
        send_bits(8'hD0, 8, 1'b1);
        checks++;
        if (nfe != 1 || nv != 0 || err_count !== 8'd1 || duty_code !== 3'd7) begin
            failures++;
            $display("FAIL frame_err ferr=%0d valids=%0d errs=%0d code=%0d exp 1/0/1/7", nfe, nv, err_count, duty_code);
        end
        send_bits(8'hF0, 8, 1'b1);
        checks++;
        if (nv != 1 || duty_code !== 3'd3) begin
            failures++;
            $display("FAIL after_frame_err code=%0d valids=%0d exp 3/1", duty_code, nv);
        end
    endtask

    task automatic test_sync_err;
        send_bits(8'hE0, 5, 1'b1);
        checks++;
        if (nv != 0 || nse != 0) begin
            failures++;
            $display("FAIL partial_quiet valids=%0d serr=%0d exp 0/0", nv, nse);
        end
        send_bits(8'hC0, 8, 1'b1);
        checks++;
        if (nse != 1 || nv != 1 || valid_idx != 7 || duty_code !== 3'd1 || err_count !== 8'd2) begin
            failures++;
            $display("FAIL sync_slip serr=%0d valids=%0d idx=%0d code=%0d errs=%0d exp 1/1/7/1/2",
                     nse, nv, valid_idx, duty_code, err_count);
        end
        // Bad-shape partial frame cut off at slot 7 by a sync: only sync_err counts.
        send_bits(8'hD0, 7, 1'b1);
        send_bits(8'hF8, 8, 1'b1);
        checks++;
        if (nse != 1 || nfe != 0 || err_count !== 8'd3 || nv != 1 || duty_code !== 3'd4) begin
            failures++;
            $display("FAIL sync_beats_frame serr=%0d ferr=%0d errs=%0d valids=%0d code=%0d exp 1/0/3/1/4",
                     nse, nfe, err_count, nv, duty_code);
        end
    endtask

    task automatic test_enable;
        send_bits(8'hF0, 3, 1'b1);
        enable = 1'b0;
        send_bits(8'hFF, 3, 1'b1);
        checks++;
        if (locked !== 1'b0 || nv + ni + nfe + nse != 0 || duty_code !== 3'd4) begin
            failures++;
            $display("FAIL disable locked=%0b pulses=%0d code=%0d exp 0/0/4", locked, nv + ni + nfe + nse, duty_code);
        end
        enable = 1'b1;
        send_bits(8'hFF, 8, 1'b0);
        checks++;
        if (locked !== 1'b0 || nv != 0 || duty_code !== 3'd4) begin
            failures++;
            $display("FAIL reenable_wait locked=%0b valids=%0d code=%0d exp 0/0/4", locked, nv, duty_code);
        end
        send_bits(8'hFC, 8, 1'b1);
        checks++;
        if (nv != 1 || duty_code !== 3'd5 || locked !== 1'b1) begin
            failures++;
            $display("FAIL resume code=%0d valids=%0d locked=%0b exp 5/1/1", duty_code, nv, locked);
        end
        send_bits(8'hFE, 8, 1'b0);
        checks++;
        if (nv != 1 || duty_code !== 3'd6) begin
            failures++;
            $display("FAIL freerun code=%0d valids=%0d exp 6/1", duty_code, nv);
        end
    endtask

    task automatic test_saturate;
        for (int k = 0; k < 300; k++) send_bits(8'hD0, 8, 1'b1);
        checks++;
        if (err_count !== 8'd255 || duty_code !== 3'd6) begin
            failures++;
            $display("FAIL err_saturate errs=%0d code=%0d exp 255/6", err_count, duty_code);
        end
        send_bits(8'hF0, 3, 1'b1);
        #2;
        clear_n = 1'b0;
        #1;
        checks++;
        if ({duty_code, duty_valid, idle, frame_err, sync_err, locked, err_count} !== 16'h0) begin
            failures++;
            $display("FAIL async_clear got=%h exp=0",
                     {duty_code, duty_valid, idle, frame_err, sync_err, locked, err_count});
        end
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        send_bits(8'hF0, 8, 1'b0);
        checks++;
        if (locked !== 1'b0 || nv != 0) begin
            failures++;
            $display("FAIL post_clear_wait locked=%0b valids=%0d exp 0/0", locked, nv);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_sweep;
        test_frame_err;
        test_sync_err;
        test_enable;
        test_saturate;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_frame_decoder.md
# pwm_frame_decoder

Serial-PWM receiver that sits directly downstream of the thermometer-PWM generator stage. That stage emits one bit per clock over an 8-slot frame: slots 0..code are high and the rest are low. This block samples that bitstream, aligns to the generator's frame-start strobe, and recovers the 3-bit duty code once per frame. It flags malformed frames, idle frames and alignment slips so the consumer can trust `duty_code` only when `duty_valid` pulses.

## Interface
- `WIDTH`, default 3: duty-code width; frame length is `2**WIDTH` slots.
- `ERR_W`, default 8: width of the saturating error counter.

- `clock` in 1: single clock; all state updates on its rising edge.
- `clear_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: decoder enable; low aborts the current frame and drops lock.
- `serial_in` in 1: PWM bit from the generator, one slot per clock.
- `frame_sync` in 1: high in the cycle where `serial_in` carries slot 0.
- `duty_code` out `WIDTH`: last successfully decoded code; holds between frames.
- `duty_valid` out 1: one-cycle pulse when `duty_code` has just been updated.
- `idle` out 1: one-cycle pulse at the end of a frame with zero high slots.
- `frame_err` out 1: one-cycle pulse at the end of a non-thermometer frame.
- `sync_err` out 1: one-cycle pulse when `frame_sync` arrives at an unexpected slot.
- `locked` out 1: high once aligned to `frame_sync`.
- `err_count` out `ERR_W`: saturating count of `frame_err` and `sync_err` events.

## Operation
- Reset values: all outputs are 0. Internal state also resets: slot counter 0, ones count 0, zero-seen flag 0, shape-bad flag 0.
- Internal state:
  - `slot` (`WIDTH` bits, wraps).
  - `ones` (`WIDTH+1` bits, range 0..`2**WIDTH`).
  - `zero_seen`, `shape_bad`.
- The state machine has two states, UNLOCKED and LOCKED; `locked` = (state == LOCKED).
- UNLOCKED: samples are ignored until `frame_sync`=1. On that edge:
  - enter LOCKED;
  - treat the current sample as slot 0: `ones` <= `serial_in`, `zero_seen` <= !`serial_in`, `shape_bad` <= 0;
  - `slot` <= 1.
- LOCKED, per sample:
  - `slot` increments and wraps.
  - `ones` += `serial_in`.
  - A 0 sample sets `zero_seen`.
  - A 1 sample while `zero_seen`=1 sets `shape_bad`.
- End of frame is the edge that samples slot `2**WIDTH-1`. The final sample is folded in combinationally, giving n = total ones. Exactly one of the following is produced on that edge:
  - n == 0: `idle` pulses.
  - shape bad: `frame_err` pulses and `err_count` increments.
  - otherwise: `duty_code` <= n-1 and `duty_valid` pulses.
  - In all cases the accumulators clear for the next frame.
- `frame_sync` while LOCKED:
  - If `slot` == 0 (expected boundary), it is a normal frame start.
  - If `slot` != 0, the partial frame is discarded with no `duty_valid`, `idle` or `frame_err`. `sync_err` pulses, `err_count` increments, and the current sample restarts as slot 0 (same actions as the UNLOCKED entry).
- Missing `frame_sync` at the expected boundary is tolerated: the block free-runs on its own slot counter.
- `enable`=0:
  - next state is UNLOCKED;
  - accumulators and `slot` clear;
  - no pulses are produced;
  - `duty_code` and `err_count` hold.
  - Re-enabling requires a new `frame_sync`.
- If `frame_err` and `sync_err` would both fire on the same edge, `sync_err` wins: the frame is discarded and `err_count` increments by 1 only.
- `err_count` saturates at all-ones.

## Timing
- All pulse outputs are registered and last exactly one cycle.
- Latency: `duty_valid` is high in the cycle after the edge that samples the last slot. This is `2**WIDTH` cycles after slot 0 is sampled.
- `frame_sync` and `serial_in` are sampled on the same edge. `frame_sync` is expected every `2**WIDTH` cycles; back-to-back frames give one `duty_valid` every 8 cycles at `WIDTH`=3.
- `locked` rises in the cycle after the first sampled `frame_sync`.
- `clear_n` asserted mid-frame: every output returns to 0 immediately (asynchronous), including `duty_code` and `err_count`. After release, the block waits for `frame_sync`.
- An `enable` change takes effect at the next edge. The sample on an edge where `enable`=0 is ignored.

## Test plan
- Reset, `enable`=1, pulse `frame_sync` every 8 cycles, and send code 3 (pattern 11110000 from slot 0) -> `locked`=1. On each frame `duty_valid` pulses with `duty_code`=3, and `err_count` stays 0.
- Sweep codes 0..7 (1..8 leading ones), then send an all-zero frame -> `duty_code` reads 0,1,...,7 in order. The all-zero frame gives an `idle` pulse, no `duty_valid`, and `duty_code` stays 7.
- Send pattern 11010000 (upstream code changing mid-frame) -> `frame_err` pulses, `err_count`=1, and `duty_code` keeps its previous value.
- Assert `frame_sync` at slot 5 of a locked frame -> `sync_err` pulses, `err_count` increments, there is no `duty_valid` for the partial frame, and the next 8 samples decode correctly.
- Drop `enable` mid-frame for 3 cycles, then raise it -> `locked`=0 with no pulses. Decoding resumes after the next `frame_sync`; `duty_code` is held throughout.
- Assert `clear_n`=0 mid-frame after 300 forced errors -> every output is 0 at once, and before the reset `err_count` had saturated at 255.
